// File: rtl/rv32_pkg.sv
// Shared RV32I register-file types and constants.
// Also holds the write-classification enum used by reg_file_onehot.
package rv32_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [NREG-1:0] reg_onehot_t;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WrIdle,
    WrValid,
    WrMulti
  } wr_class_e;

  // Precedence matters only for corrupt vectors: multi-hot always wins.
  function automatic wr_class_e classify(input logic is_zero, input logic is_one,
                                         input logic is_multi);
    wr_class_e cls;
    cls = WrIdle;
    if (is_multi) begin
      cls = WrMulti;
    end else if (is_one && !is_zero) begin
      cls = WrValid;
    end
    return cls;
  endfunction

endpackage

// File: rtl/reg_file_onehot_if.sv
// Write-back / operand-read bus of the register file.
// The master is the pipeline side; the slave is reg_file_onehot.
interface reg_file_onehot_if
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  reg_onehot_t            wr_enable;
  word_t                  wr_data;
  logic [REG_IDX_W-1:0]   rs1;
  logic [REG_IDX_W-1:0]   rs2;
  word_t                  rd1;
  word_t                  rd2;
  logic                   err_clr;
  logic                   onehot_err;
  logic [CNT_W-1:0]       wr_count;

  modport master (
    output wr_enable,
    output wr_data,
    output rs1,
    output rs2,
    output err_clr,
    input  rd1,
    input  rd2,
    input  onehot_err,
    input  wr_count
  );

  modport slave (
    input  wr_enable,
    input  wr_data,
    input  rs1,
    input  rs2,
    input  err_clr,
    output rd1,
    output rd2,
    output onehot_err,
    output wr_count
  );

endinterface

// File: rtl/onehot_check.sv
// Classifies a register-select enable vector as zero / one-hot / multi-hot
// and encodes the index of the set bit (meaningful only when is_one).
module onehot_check
  import rv32_pkg::*;
(
  input  reg_onehot_t          onehot,
  output logic                 is_zero,
  output logic                 is_one,
  output logic                 is_multi,
  output logic [REG_IDX_W-1:0] idx
);

  logic [REG_IDX_W:0] w_popcnt;
  logic [REG_IDX_W-1:0] w_idx;

  always_comb begin
    w_popcnt = '0;
    w_idx    = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_popcnt = w_popcnt + {{REG_IDX_W{1'b0}}, onehot[i]};
      // OR-encoding is exact for one-hot inputs and harmless otherwise.
      if (onehot[i]) begin
        w_idx = w_idx | REG_IDX_W'(i);
      end
    end
  end

  assign is_zero  = (w_popcnt == '0);
  assign is_one   = (w_popcnt == (REG_IDX_W + 1)'(1));
  assign is_multi = (w_popcnt > (REG_IDX_W + 1)'(1));
  assign idx      = w_idx;

endmodule

// File: rtl/reg_file_onehot.sv
// 32 x 32-bit RV32I register file with one-hot write enable, sticky multi-hot
// error flag and committed-write counter. Optional macro RF_BYPASS_EN.
module reg_file_onehot
  import rv32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_file_onehot_if.slave   bus
);

  word_t                r_regs [NREG];
  logic                 r_err;
  logic [CNT_W-1:0]     r_count;

  logic                 w_is_zero;
  logic                 w_is_one;
  logic                 w_is_multi;
  logic [REG_IDX_W-1:0] w_idx;
  wr_class_e            w_class;
  logic                 w_commit;
  word_t                w_rd1;
  word_t                w_rd2;

  onehot_check u_onehot_check (
    .onehot   (bus.wr_enable),
    .is_zero  (w_is_zero),
    .is_one   (w_is_one),
    .is_multi (w_is_multi),
    .idx      (w_idx)
  );

  assign w_class  = classify(w_is_zero, w_is_one, w_is_multi);
  // x0 is hardwired: a one-hot write to it is a silent no-op.
  assign w_commit = (w_class == WrValid) && (w_idx != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[w_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_commit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Set has priority over clear so a corrupt vector is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_class == WrMulti) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_comb begin
    w_rd1 = (bus.rs1 == REG_ZERO) ? '0 : r_regs[bus.rs1];
    w_rd2 = (bus.rs2 == REG_ZERO) ? '0 : r_regs[bus.rs2];
`ifdef RF_BYPASS_EN
    if (w_commit && (bus.rs1 == w_idx)) begin
      w_rd1 = bus.wr_data;
    end
    if (w_commit && (bus.rs2 == w_idx)) begin
      w_rd2 = bus.wr_data;
    end
`else
`endif
  end

  assign bus.rd1        = w_rd1;
  assign bus.rd2        = w_rd2;
  assign bus.onehot_err = r_err;
  assign bus.wr_count   = r_count;

endmodule
